// File: rtl/scb_pkg.sv
// Shared types and helpers for the register-hazard scoreboard.
package scb_pkg;

  localparam int unsigned DEF_NREG   = 8;
  localparam int unsigned DEF_WB_LAT = 3;

  function automatic int unsigned cnt_width(input int unsigned wb_lat);
    return $clog2(wb_lat + 1);
  endfunction

  // Counters strictly above this value belong to writers squashed by a flush.
  function automatic int unsigned kill_thresh(input int unsigned wb_lat,
                                              input int unsigned kill_depth);
    return wb_lat - kill_depth;
  endfunction

  typedef logic [cnt_width(DEF_WB_LAT)-1:0] scb_cnt_t;
  typedef logic [$clog2(DEF_NREG)-1:0]      scb_reg_t;

endpackage

// File: rtl/scb_counter.sv
// Per-register pending-write down-counter: load on issue, saturating decrement,
// clear of young writers on flush.
module scb_counter
  import scb_pkg::*;
#(
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned KILL_DEPTH = 1,
  parameter int unsigned CW         = cnt_width(WB_LAT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(WB_LAT);
  localparam logic [CW-1:0] KILL_TH  = CW'(kill_thresh(WB_LAT, KILL_DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (flush && (cnt > KILL_TH)) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register writeback countdown, decode stall
// and bubble control. Optional WB-stage bypass enabled by SCB_FORWARD_EN.
module hazard_scoreboard
  import scb_pkg::*;
#(
  parameter int unsigned NREG       = 8,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned KILL_DEPTH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic                          issue_we,
  input  logic [$clog2(NREG)-1:0]       issue_rd,
  input  logic [NSRC*$clog2(NREG)-1:0]  src_adr,
  input  logic [NSRC-1:0]               src_used,
  input  logic                          flush,
  output logic                          stall,
  output logic                          en_pc,
  output logic                          en_ifid,
  output logic                          flush_idex,
  output logic                          issued,
  output logic [NREG-1:0]               busy,
  output logic [NSRC-1:0]               fwd_hit
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = cnt_width(WB_LAT);

  logic [CW-1:0]   cnt      [NREG];
  logic [CW-1:0]   port_cnt [NSRC];
  logic [NSRC-1:0] hazard;

  // flush blocks issue, so a squashed instruction never loads its counter
  assign issued     = issue_valid & ~stall & ~flush;
  assign stall      = issue_valid & (|hazard);
  assign en_pc      = ~stall;
  assign en_ifid    = ~stall;
  assign flush_idex = stall | flush;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    scb_counter #(
      .WB_LAT     (WB_LAT),
      .KILL_DEPTH (KILL_DEPTH),
      .CW         (CW)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (issued & issue_we & (issue_rd == AW'(r))),
      .flush (flush),
      .cnt   (cnt[r])
    );
    assign busy[r] = |cnt[r];
  end

  for (genvar p = 0; p < NSRC; p++) begin : g_port
    assign port_cnt[p] = cnt[src_adr[p*AW +: AW]];
`ifdef SCB_FORWARD_EN
    // A count of 1 means the value is in WB and can be bypassed to decode.
    assign fwd_hit[p] = src_used[p] & (port_cnt[p] == CW'(1));
    assign hazard[p]  = src_used[p] & (port_cnt[p] != '0) & ~fwd_hit[p];
`else
    assign fwd_hit[p] = 1'b0;
    assign hazard[p]  = src_used[p] & (port_cnt[p] != '0);
`endif
  end

endmodule
